dmem_arbiter: RTL and testbench

- Shares the single-port dmem syncram between two requesters: port 0 (processor) and port 1 (debug/loader, e.g. testbench or boot path).
- Sits between the requesters and the dmem instance in the skeleton. Drives address_dmem, data and wren; returns q_dmem to the owning port.
- Issues at most one access per cycle. Arbitration is priority or round-robin, with a starvation bound.

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/arb_rr2.sv | 34 +++
 rtl/dmem_arbiter.sv | 70 +++++++
 tb/tb_dmem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared port indices, read-return tag type and default widths for the dmem arbiter
package dmem_arb_pkg;
    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;
    localparam logic PORT_PROC = 1'b0;
    localparam logic PORT_DBG = 1'b1;
    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way arbiter, fixed priority with starvation guard or round-robin
module arb_rr2 import dmem_arb_pkg::*; #(
    parameter int PROC_PRIO = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic any,
    output logic sel
);
    logic last;
    logic [3:0] wait_cnt;
    assign any = req0 | req1;
    always_comb begin
        sel = req1 ? PORT_DBG : PORT_PROC;
        if (req0 && req1)
            sel = (PROC_PRIO != 0) ? ((wait_cnt == 4'(MAX_WAIT)) ? PORT_DBG : PORT_PROC) : ~last;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= PORT_DBG;
            wait_cnt <= '0;
        end else begin
            if (any)
                last <= sel;
            if (!req1 || sel == PORT_DBG)
                wait_cnt <= '0;
            else if (wait_cnt != 4'(MAX_WAIT))
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the processor and the debug/loader port
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int MEM_LAT = 1,
    parameter int PROC_PRIO = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);
    logic any, sel, we_sel;
    tag_t tags [MEM_LAT];
    arb_rr2 #(.PROC_PRIO(PROC_PRIO), .MAX_WAIT(MAX_WAIT)) u_arb (
        .clock(clock),
        .reset(reset),
        .req0(req0),
        .req1(req1),
        .any(any),
        .sel(sel)
    );
    assign we_sel = sel ? we1 : we0;
    assign rdata0 = q_dmem;
    assign rdata1 = q_dmem;
    // The tag pipe is as deep as the memory latency, so a tag leaves it exactly as its data arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            wren <= 1'b0;
            address_dmem <= '0;
            data <= '0;
            for (int i = 0; i < MEM_LAT; i++)
                tags[i] <= '0;
        end else begin
            gnt0 <= any && sel == PORT_PROC;
            gnt1 <= any && sel == PORT_DBG;
            wren <= any && we_sel;
            if (any) begin
                address_dmem <= sel ? addr1 : addr0;
                data <= sel ? wdata1 : wdata0;
            end
            tags[0] <= '{valid: any && !we_sel, port: sel};
            for (int i = 1; i < MEM_LAT; i++)
                tags[i] <= tags[i-1];
            rvalid0 <= tags[MEM_LAT-1].valid && tags[MEM_LAT-1].port == PORT_PROC;
            rvalid1 <= tags[MEM_LAT-1].valid && tags[MEM_LAT-1].port == PORT_DBG;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: priority/latency-1 and round-robin/latency-3 arbiters against a behavioural model
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;
    typedef struct { int due; bit port; logic [31:0] d; } rd_t;
    logic clock = 0, reset = 1;
    logic req0 [2], we0 [2], req1 [2], we1 [2], gnt0 [2], gnt1 [2], rvalid0 [2], rvalid1 [2], wren [2];
    logic [11:0] addr0 [2], addr1 [2], address_dmem [2];
    logic [31:0] wdata0 [2], wdata1 [2], rdata0 [2], rdata1 [2], data [2], q_dmem [2];
    logic [31:0] mem [2][4096];
    logic [31:0] qp [2][4];
    logic [31:0] ref_mem [2][4096];
    rd_t rq [2][$];
    bit m_last [2];
    int m_denied [2];
    int edge_n = 0;
    bit e_gnt0 [2], e_gnt1 [2], e_wren [2], e_rv0 [2], e_rv1 [2];
    logic [11:0] e_addr [2];
    logic [31:0] e_data [2], e_rd [2];
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MEM_LAT(1), .PROC_PRIO(1), .MAX_WAIT(MAX_WAIT)) u_prio (
        .clock(clock), .reset(reset),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .gnt0(gnt0[0]), .rvalid0(rvalid0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .gnt1(gnt1[0]), .rvalid1(rvalid1[0]), .rdata1(rdata1[0]),
        .address_dmem(address_dmem[0]), .data(data[0]), .wren(wren[0]), .q_dmem(q_dmem[0])
    );
    dmem_arbiter #(.MEM_LAT(3), .PROC_PRIO(0), .MAX_WAIT(MAX_WAIT)) u_rr (
        .clock(clock), .reset(reset),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .gnt0(gnt0[1]), .rvalid0(rvalid0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .gnt1(gnt1[1]), .rvalid1(rvalid1[1]), .rdata1(rdata1[1]),
        .address_dmem(address_dmem[1]), .data(data[1]), .wren(wren[1]), .q_dmem(q_dmem[1])
    );

    // dmem syncram: samples the registered address each edge, data emerges MEM_LAT cycles later
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 3; s > 0; s--)
                qp[k][s] <= qp[k][s-1];
            qp[k][0] <= mem[k][address_dmem[k]];
            if (wren[k])
                mem[k][address_dmem[k]] <= data[k];
        end
    end
    assign q_dmem[0] = qp[0][0];
    assign q_dmem[1] = qp[1][2];

    function automatic int lat(int k);
        return k == 0 ? 1 : 3;
    endfunction

    task automatic set_port(int p, bit r, bit w, logic [11:0] a, logic [31:0] d);
        for (int k = 0; k < 2; k++)
            if (p == 0) begin
                req0[k] = r; we0[k] = w; addr0[k] = a; wdata0[k] = d;
            end else begin
                req1[k] = r; we1[k] = w; addr1[k] = a; wdata1[k] = d;
            end
    endtask

    task automatic idle();
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
    endtask

    // Model: winner from the arbitration rules, reads queued with their due edge and issue-order data.
    task automatic cycle();
        for (int k = 0; k < 2; k++) begin
            bit any, w, wr;
            any = req0[k] || req1[k];
            w = (req0[k] && req1[k]) ? (k == 0 ? m_denied[k] == MAX_WAIT : !m_last[k]) : req1[k];
            wr = w ? we1[k] : we0[k];
            e_gnt0[k] = !reset && any && !w;
            e_gnt1[k] = !reset && any && w;
            e_wren[k] = !reset && any && wr;
            if (reset) begin
                m_last[k] = 1;
                m_denied[k] = 0;
                rq[k].delete();
                e_addr[k] = 0;
                e_data[k] = 0;
            end else begin
                m_denied[k] = (req1[k] && !w) ? (m_denied[k] < MAX_WAIT ? m_denied[k] + 1 : MAX_WAIT) : 0;
                if (any) begin
                    m_last[k] = w;
                    e_addr[k] = w ? addr1[k] : addr0[k];
                    e_data[k] = w ? wdata1[k] : wdata0[k];
                    if (wr)
                        ref_mem[k][e_addr[k]] = e_data[k];
                    else
                        rq[k].push_back('{due: edge_n + 1 + lat(k), port: w, d: ref_mem[k][e_addr[k]]});
                end
            end
        end
        @(posedge clock);
        edge_n++;
        #1;
        for (int k = 0; k < 2; k++) begin
            rd_t r;
            e_rv0[k] = 0;
            e_rv1[k] = 0;
            if (rq[k].size() != 0 && rq[k][0].due == edge_n) begin
                r = rq[k].pop_front();
                e_rv0[k] = !r.port;
                e_rv1[k] = r.port;
                e_rd[k] = r.d;
            end
        end
    endtask

    task automatic test_reset();
        set_port(0, 1, 1, 12'h3, 32'h5);
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], wren[k]} !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_ctrl[%0d] got %b want 00000", k, {gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], wren[k]});
                end
                checks++;
                if (address_dmem[k] !== 12'h0 || data[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_bus[%0d] got addr %h data %h want 0 0", k, address_dmem[k], data[k]);
                end
            end
        end
        reset = 0;
        idle();
    endtask

    task automatic load_mem();
        for (int a = 0; a < 64; a++) begin
            set_port(1, 1, 1, 12'(a), a == 16 ? 32'hDEADBEEF : $urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({gnt0[k], gnt1[k], wren[k]} !== 3'b011 || address_dmem[k] !== 12'(a)) begin
                    errors++;
                    $display("FAIL load[%0d] a=%0d got gnt %b%b wren %b addr %h want 0 1 1 %h",
                             k, a, gnt0[k], gnt1[k], wren[k], address_dmem[k], 12'(a));
                end
            end
        end
        idle();
    endtask

    task automatic test_read();
        set_port(0, 1, 0, 12'h010, 0);
        cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({gnt0[k], gnt1[k], wren[k]} !== 3'b100 || address_dmem[k] !== 12'h010) begin
                errors++;
                $display("FAIL read_gnt[%0d] got gnt %b%b wren %b addr %h want 1 0 0 010", k, gnt0[k], gnt1[k], wren[k], address_dmem[k]);
            end
        end
        idle();
        for (int i = 1; i <= 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rvalid0[k], rvalid1[k], gnt0[k], gnt1[k]} !== {i == lat(k), 3'b000}) begin
                    errors++;
                    $display("FAIL read_rvalid[%0d] cyc %0d got %b%b gnt %b%b want %b0 00", k, i, rvalid0[k], rvalid1[k], gnt0[k], gnt1[k], i == lat(k));
                end
                if (i == lat(k)) begin
                    checks++;
                    if (rdata0[k] !== 32'hDEADBEEF) begin
                        errors++;
                        $display("FAIL read_data[%0d] got %h want deadbeef", k, rdata0[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_write_read();
        set_port(0, 1, 1, 12'h020, 32'h12345678);
        cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({gnt0[k], gnt1[k], wren[k]} !== 3'b101 || data[k] !== 32'h12345678 || address_dmem[k] !== 12'h020) begin
                errors++;
                $display("FAIL wr_issue[%0d] got gnt %b%b wren %b data %h addr %h want 1 0 1 12345678 020",
                         k, gnt0[k], gnt1[k], wren[k], data[k], address_dmem[k]);
            end
        end
        set_port(0, 0, 0, 0, 0);
        set_port(1, 1, 0, 12'h020, 0);
        cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({gnt0[k], gnt1[k], wren[k]} !== 3'b010) begin
                errors++;
                $display("FAIL rd_issue[%0d] got gnt %b%b wren %b want 0 1 0", k, gnt0[k], gnt1[k], wren[k]);
            end
        end
        idle();
        for (int i = 1; i <= 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rvalid0[k], rvalid1[k]} !== {1'b0, i == lat(k)}) begin
                    errors++;
                    $display("FAIL wr_rd_rvalid[%0d] cyc %0d got %b%b want 0%b", k, i, rvalid0[k], rvalid1[k], i == lat(k));
                end
                if (i == lat(k)) begin
                    checks++;
                    if (rdata1[k] !== 32'h12345678) begin
                        errors++;
                        $display("FAIL wr_rd_data[%0d] got %h want 12345678", k, rdata1[k]);
                    end
                end
            end
        end
    endtask

    // Both ports held high: priority grants port 1 every 5th cycle, round-robin alternates from port 0.
    task automatic test_conflict();
        reset = 1;
        idle();
        cycle();
        reset = 0;
        set_port(0, 1, 0, 12'h001, 0);
        set_port(1, 1, 0, 12'h002, 0);
        for (int i = 1; i <= 13; i++) begin
            cycle();
            if (i == 10)
                idle();
            for (int k = 0; k < 2; k++) begin
                bit g1, rv, rp;
                int j;
                g1 = k == 0 ? (i % 5 == 0) : (i % 2 == 0);
                j = i - lat(k);
                rv = j >= 1 && j <= 10;
                rp = k == 0 ? (j % 5 == 0) : (j % 2 == 0);
                checks++;
                if ({gnt0[k], gnt1[k]} !== (i <= 10 ? {!g1, g1} : 2'b00)) begin
                    errors++;
                    $display("FAIL conflict_gnt[%0d] cyc %0d got %b%b want %b", k, i, gnt0[k], gnt1[k], i <= 10 ? {!g1, g1} : 2'b00);
                end
                checks++;
                if ({rvalid0[k], rvalid1[k]} !== {rv && !rp, rv && rp}) begin
                    errors++;
                    $display("FAIL conflict_rvalid[%0d] cyc %0d got %b%b want %b%b", k, i, rvalid0[k], rvalid1[k], rv && !rp, rv && rp);
                end
                if (rv) begin
                    checks++;
                    if ((rp ? rdata1[k] : rdata0[k]) !== ref_mem[k][rp ? 2 : 1]) begin
                        errors++;
                        $display("FAIL conflict_data[%0d] cyc %0d got %h want %h", k, i, rp ? rdata1[k] : rdata0[k], ref_mem[k][rp ? 2 : 1]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 7; i++) begin
            idle();
            if (i <= 4)
                set_port((i - 1) % 2, 1, 0, 12'(i - 1), 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                int j;
                bit rv, rp;
                j = i - lat(k);
                rv = j >= 1 && j <= 4;
                rp = (j - 1) % 2 == 1;
                if (i <= 4) begin
                    checks++;
                    if ({gnt0[k], gnt1[k]} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL b2b_gnt[%0d] cyc %0d got %b%b", k, i, gnt0[k], gnt1[k]);
                    end
                end
                checks++;
                if ({rvalid0[k], rvalid1[k]} !== {rv && !rp, rv && rp}) begin
                    errors++;
                    $display("FAIL b2b_rvalid[%0d] cyc %0d got %b%b want %b%b", k, i, rvalid0[k], rvalid1[k], rv && !rp, rv && rp);
                end
                if (rv) begin
                    checks++;
                    if ((rp ? rdata1[k] : rdata0[k]) !== ref_mem[k][j - 1]) begin
                        errors++;
                        $display("FAIL b2b_data[%0d] cyc %0d got %h want %h", k, i, rp ? rdata1[k] : rdata0[k], ref_mem[k][j - 1]);
                    end
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_inflight();
        set_port(0, 1, 0, 12'h005, 0);
        cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt0[k] !== 1'b1) begin
                errors++;
                $display("FAIL inflight_gnt[%0d] got %b want 1", k, gnt0[k]);
            end
        end
        idle();
        set_port(1, 1, 1, 12'h007, 32'hBAD0BAD0);
        reset = 1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (i == 2) begin
                reset = 0;
                idle();
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], wren[k]} !== 5'b0 || address_dmem[k] !== 12'h0 || data[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL inflight_quiet[%0d] cyc %0d got ctl %b addr %h data %h want 0",
                             k, i, {gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], wren[k]}, address_dmem[k], data[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit pend [2][2];
        for (int k = 0; k < 2; k++) begin
            pend[k][0] = 0;
            pend[k][1] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k][0]) begin
                    pend[k][0] = $urandom_range(2, 0) != 0;
                    req0[k] = pend[k][0]; we0[k] = $urandom_range(1, 0) != 0;
                    addr0[k] = 12'($urandom_range(31, 0)); wdata0[k] = $urandom;
                end
                if (!pend[k][1]) begin
                    pend[k][1] = $urandom_range(2, 0) != 0;
                    req1[k] = pend[k][1]; we1[k] = $urandom_range(1, 0) != 0;
                    addr1[k] = 12'($urandom_range(31, 0)); wdata1[k] = $urandom;
                end
            end
            reset = $urandom_range(39, 0) == 0;
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({gnt0[k], gnt1[k], wren[k], rvalid0[k], rvalid1[k]} !== {e_gnt0[k], e_gnt1[k], e_wren[k], e_rv0[k], e_rv1[k]}) begin
                    errors++;
                    $display("FAIL rand_ctl[%0d] n=%0d got gnt/wren/rv %b want %b", k, n,
                             {gnt0[k], gnt1[k], wren[k], rvalid0[k], rvalid1[k]}, {e_gnt0[k], e_gnt1[k], e_wren[k], e_rv0[k], e_rv1[k]});
                end
                checks++;
                if (address_dmem[k] !== e_addr[k] || data[k] !== e_data[k]) begin
                    errors++;
                    $display("FAIL rand_bus[%0d] n=%0d got %h/%h want %h/%h", k, n, address_dmem[k], data[k], e_addr[k], e_data[k]);
                end
                if (e_rv0[k] || e_rv1[k]) begin
                    checks++;
                    if ((e_rv0[k] ? rdata0[k] : rdata1[k]) !== e_rd[k]) begin
                        errors++;
                        $display("FAIL rand_data[%0d] n=%0d got %h want %h", k, n, e_rv0[k] ? rdata0[k] : rdata1[k], e_rd[k]);
                    end
                end
                if (e_gnt0[k])
                    pend[k][0] = 0;
                if (e_gnt1[k])
                    pend[k][1] = 0;
            end
        end
        reset = 0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        load_mem();
        test_read();
        test_write_read();
        test_conflict();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
